// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Widest result the clamp helper can produce; callers slice the low WIDTH bits.
  localparam int unsigned SatMaxWidth = 64;

  // Saturation value for a width-bit two's complement result: MIN if neg, else MAX.
  function automatic logic [SatMaxWidth-1:0] sat_clamp(input int unsigned width, input logic neg);
    logic [SatMaxWidth-1:0] one_v;
    logic [SatMaxWidth-1:0] min_v;
    one_v = {{(SatMaxWidth-1){1'b0}}, 1'b1};
    min_v = one_v << (width - 1);
    return neg ? min_v : (min_v - one_v);
  endfunction

endpackage

// File: rtl/calc_iter_step.sv
// One iteration of the multi-cycle datapath.
// MUL: right-shifting shift-and-add; work = {partial_hi, remaining multiplier bits}.
// DIV: restoring division; work = {partial remainder, dividend/quotient bits}.
module calc_iter_step
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]         op_i,
  input  logic [2*WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] work_o
);

  logic [WIDTH:0]   hi_sum;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   top;
  logic [WIDTH:0]   diff;

  // Compute the next work register for the selected operation.
  always_comb begin
    hi_sum  = '0;
    shifted = '0;
    top     = '0;
    diff    = '0;
    work_o  = work_i;
    if (op_i == OP_DIV) begin
      shifted = {work_i, 1'b0};
      top     = shifted[2*WIDTH:WIDTH];
      diff    = top - {1'b0, m_i};
      // Non-negative trial difference: keep it and set this quotient bit.
      if (!diff[WIDTH]) begin
        work_o = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
      end else begin
        work_o = {top[WIDTH-1:0], shifted[WIDTH-1:0]};
      end
    end else begin
      hi_sum = {1'b0, work_i[2*WIDTH-1:WIDTH]} + (work_i[0] ? {1'b0, m_i} : '0);
      work_o = {hi_sum, work_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle signed ADD/SUB/MUL/DIV sequencer with valid/ready on both sides.
// Optional feature: define CALC_SAT_EN to clamp overflowing results to MIN/MAX.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_ovf,
  output logic             out_dz
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q, m_q;
  logic [2*WIDTH-1:0] work_q, work_step;
  logic [CntW-1:0]    cnt_q;
  logic               out_valid_q, ovf_q, dz_q;
  logic [WIDTH-1:0]   result_q, rem_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     a_ext, b_ext, add_sum;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_mag, rem_mag;
  logic [WIDTH-1:0]   fin_wrap, fin_res, fin_rem;
  logic               fin_ovf;

  // Magnitudes of the incoming operands; |MIN| still fits as an unsigned WIDTH-bit value.
  assign mag_a = in_a[WIDTH-1] ? -in_a : in_a;
  assign mag_b = in_b[WIDTH-1] ? -in_b : in_b;

  assign a_ext   = {a_q[WIDTH-1], a_q};
  assign b_ext   = {b_q[WIDTH-1], b_q};
  assign add_sum = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
  assign res_neg = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign prod    = res_neg ? -work_q : work_q;
  assign quo_mag = work_q[WIDTH-1:0];
  assign rem_mag = work_q[2*WIDTH-1:WIDTH];

  calc_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op_i  (op_q),
    .work_i(work_q),
    .m_i   (m_q),
    .work_o(work_step)
  );

  // Sign fix-up and overflow detection for the finished operation (wrapping result).
  always_comb begin
    fin_wrap = '0;
    fin_rem  = '0;
    fin_ovf  = 1'b0;
    unique case (op_q)
      OP_ADD, OP_SUB: begin
        fin_wrap = add_sum[WIDTH-1:0];
        fin_ovf  = add_sum[WIDTH] ^ add_sum[WIDTH-1];
      end
      OP_MUL: begin
        fin_wrap = prod[WIDTH-1:0];
        // Fits in WIDTH bits only if the upper bits are a pure sign extension.
        fin_ovf  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
      end
      OP_DIV: begin
        fin_wrap = res_neg ? -quo_mag : quo_mag;
        fin_rem  = a_q[WIDTH-1] ? -rem_mag : rem_mag;
        // Only MIN / -1 yields a positive quotient of 2^(W-1).
        fin_ovf  = !res_neg && quo_mag[WIDTH-1];
      end
      default: ;
    endcase
  end

`ifdef CALC_SAT_EN
  logic                   fin_neg;
  logic [SatMaxWidth-1:0] clamp_val;

  // Sign of the true (unwrapped) result, used to pick the clamp direction.
  always_comb begin
    unique case (op_q)
      OP_ADD, OP_SUB: fin_neg = add_sum[WIDTH];
      default:        fin_neg = res_neg;
    endcase
  end

  assign clamp_val = sat_clamp(WIDTH, fin_neg);
  assign fin_res   = fin_ovf ? clamp_val[WIDTH-1:0] : fin_wrap;
`else
  assign fin_res = fin_wrap;
`endif

  // Control FSM with registered outputs; one transaction in flight at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= op_e'(in_op);
            a_q     <= in_a;
            b_q     <= in_b;
            cnt_q   <= '0;
            state_q <= S_EXEC;
            if (in_op == OP_DIV) begin
              work_q <= {{WIDTH{1'b0}}, mag_a};
              m_q    <= mag_b;
            end else begin
              work_q <= {{WIDTH{1'b0}}, mag_b};
              m_q    <= mag_a;
            end
          end
        end
        S_EXEC: begin
          if (op_q == OP_DIV && b_q == '0) begin
            result_q    <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (op_q == OP_ADD || op_q == OP_SUB || cnt_q == CntW'(WIDTH)) begin
            result_q    <= fin_res;
            rem_q       <= fin_rem;
            ovf_q       <= fin_ovf;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            work_q <= work_step;
            cnt_q  <= cnt_q + CntW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_rem    = rem_q;
  assign out_ovf    = ovf_q;
  assign out_dz     = dz_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer (WIDTH=8): integer reference model plus
// directed vectors with hand-computed literals.
module tb_calc_sequencer;

  localparam int W    = 8;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpMul = 2'd2;
  localparam logic [1:0] OpDiv = 2'd3;

`ifdef CALC_SAT_EN
  localparam bit SatBuild = 1'b1;
`else
  localparam bit SatBuild = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dz;
    logic [31:0]  lat;
  } exp_t;

  typedef struct packed {
    exp_t        e;
    logic [31:0] acc;
    logic [31:0] due;
  } pend_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [1:0]   in_op = 2'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, out_valid, out_ovf, out_dz;
  logic [W-1:0] out_result, out_rem;

  calc_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_rem   (out_rem),
    .out_ovf   (out_ovf),
    .out_dz    (out_dz)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_edge = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_edge <= rst;

  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  int           acc_cnt = 0;
  int           last_lat = 0;
  logic [W-1:0] last_res = '0;
  logic [W-1:0] last_rem = '0;
  logic         last_ovf = 1'b0;
  logic         last_dz = 1'b0;
  pend_t        q[$];
  pend_t        p;
  logic         head_seen = 1'b0;
  logic         exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  // Reference: exact integer arithmetic, then range test and truncation.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int   sa, sb, t, r;
    sa    = $signed(a);
    sb    = $signed(b);
    e     = '0;
    t     = 0;
    r     = 0;
    e.lat = 1;
    case (op)
      OpAdd: t = sa + sb;
      OpSub: t = sa - sb;
      OpMul: begin
        t     = sa * sb;
        e.lat = W + 1;
      end
      default: begin
        if (sb == 0) begin
          e.dz = 1'b1;
        end else begin
          t     = sa / sb;
          r     = sa % sb;
          e.lat = W + 1;
        end
      end
    endcase
    e.ovf = (t > MAXV) || (t < MINV);
    if (SatBuild && e.ovf) t = (t > 0) ? MAXV : MINV;
    e.res = t[W-1:0];
    e.rem = r[W-1:0];
    return e;
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_ready = !rst && (q.size() == 0);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (rst_edge) begin
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_result", 32'(out_result), 32'd0);
      chk("reset_rem", 32'(out_rem), 32'd0);
      chk("reset_ovf", 32'(out_ovf), 32'd0);
      chk("reset_dz", 32'(out_dz), 32'd0);
    end
    if (rst) begin
      q.delete();
      head_seen = 1'b0;
    end else begin
      if (q.size() != 0) begin
        if (out_valid) begin
          if (!head_seen) begin
            chk("latency", cyc, q[0].due);
            head_seen = 1'b1;
            last_lat  = cyc - int'(q[0].acc);
          end
          chk("result", 32'(out_result), 32'(q[0].e.res));
          chk("rem", 32'(out_rem), 32'(q[0].e.rem));
          chk("ovf", 32'(out_ovf), 32'(q[0].e.ovf));
          chk("dz", 32'(out_dz), 32'(q[0].e.dz));
          if (out_ready) begin
            last_res = out_result;
            last_rem = out_rem;
            last_ovf = out_ovf;
            last_dz  = out_dz;
            done_cnt++;
            void'(q.pop_front());
            head_seen = 1'b0;
          end
        end else if (head_seen) begin
          fail("valid_dropped_before_handshake");
          void'(q.pop_front());
          head_seen = 1'b0;
        end else if (cyc > int'(q[0].due)) begin
          fail("valid_timeout");
          void'(q.pop_front());
        end
      end else if (out_valid) begin
        fail("no_spurious_valid");
      end
      if (in_valid && exp_ready) begin
        p.e   = model(in_op, in_a, in_b);
        p.acc = cyc + 1;
        p.due = cyc + 1 + int'(p.e.lat);
        q.push_back(p);
        acc_cnt++;
      end
    end
  end

  // Present one transaction; returns just after the accepting edge, operands scrambled.
  task automatic send(input logic [1:0] op, input int a, input int b);
    int          n;
    int          a0;
    logic [31:0] rnd;
    a0       = acc_cnt;
    in_op    = op;
    in_a     = a[W-1:0];
    in_b     = b[W-1:0];
    in_valid = 1'b1;
    n        = 0;
    while (acc_cnt == a0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (acc_cnt == a0) fail("accept_timeout");
    in_valid = 1'b0;
    rnd      = $urandom;
    in_a     = rnd[W-1:0];
    in_b     = rnd[2*W-1:W];
    in_op    = rnd[17:16];
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) fail("result_timeout");
  endtask

  // Directed vector with literal expectations for the handshaken result.
  task automatic run(input logic [1:0] op, input int a, input int b, input int res,
                     input int res_sat, input int rem, input logic ovf, input logic dz,
                     input int lat);
    int d0;
    int r;
    d0 = done_cnt;
    send(op, a, b);
    wait_done(d0);
    r = SatBuild ? res_sat : res;
    chk("lit_result", 32'(last_res), 32'(r[W-1:0]));
    chk("lit_rem", 32'(last_rem), 32'(rem[W-1:0]));
    chk("lit_ovf", 32'(last_ovf), 32'(ovf));
    chk("lit_dz", 32'(last_dz), 32'(dz));
    chk("lit_latency", last_lat, lat);
  endtask

  initial begin
    int d0;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    //  op     a     b     res    res_sat rem   ovf   dz    lat
    run(OpAdd, 100,  50,   'h96,  'h7F,   0,    1'b1, 1'b0, 1);
    run(OpMul, 7,    15,   105,   105,    0,    1'b0, 1'b0, 9);
    run(OpMul, -12,  11,   'h7C,  'h80,   0,    1'b1, 1'b0, 9);
    run(OpDiv, -7,   2,    -3,    -3,     -1,   1'b0, 1'b0, 9);
    run(OpDiv, 5,    0,    0,     0,      0,    1'b0, 1'b1, 1);
    run(OpDiv, -128, -1,   'h80,  'h7F,   0,    1'b1, 1'b0, 9);
    run(OpSub, -128, 1,    'h7F,  'h80,   0,    1'b1, 1'b0, 1);
    run(OpSub, 0,    -128, 'h80,  'h7F,   0,    1'b1, 1'b0, 1);
    run(OpAdd, -1,   1,    0,     0,      0,    1'b0, 1'b0, 1);
    run(OpSub, 5,    7,    -2,    -2,     0,    1'b0, 1'b0, 1);
    run(OpMul, -128, 1,    'h80,  'h80,   0,    1'b0, 1'b0, 9);
    run(OpMul, -128, -1,   'h80,  'h7F,   0,    1'b1, 1'b0, 9);
    run(OpMul, -16,  8,    'h80,  'h80,   0,    1'b0, 1'b0, 9);
    run(OpMul, 127,  127,  'h01,  'h7F,   0,    1'b1, 1'b0, 9);
    run(OpMul, 0,    -5,   0,     0,      0,    1'b0, 1'b0, 9);
    run(OpDiv, 7,    -2,   -3,    -3,     1,    1'b0, 1'b0, 9);
    run(OpDiv, 127,  -128, 0,     0,      127,  1'b0, 1'b0, 9);
    run(OpDiv, -128, 3,    -42,   -42,    -2,   1'b0, 1'b0, 9);

    // Backpressure: result held while out_ready is low; new requests ignored.
    out_ready = 1'b0;
    d0        = done_cnt;
    send(OpMul, 3, 4);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) fail("bp_valid_timeout");
    in_valid = 1'b1;
    in_op    = OpAdd;
    in_a     = 8'd1;
    in_b     = 8'd1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done(d0);
    chk("bp_result", 32'(last_res), 32'd12);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("bp_ignored_request", done_cnt, d0 + 1);

    // Reset in the middle of a MUL aborts it without any output.
    d0 = done_cnt;
    send(OpMul, 15, 7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    chk("abort_no_result", done_cnt, d0);
    run(OpAdd, 2, 3, 5, 5, 0, 1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
